// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
package regfile_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/regfile.sv
// 31 x 32-bit register file with x0 hardwired to zero, two combinational
// read ports and write-through bypass from the single write port.
// Note: rst_ni is active-high despite its suffix; the name is kept so that
// existing instantiations continue to connect.
module regfile
    import regfile_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    input  logic [REG_IDX_W-1:0] rsW_i,
    input  logic [XLEN-1:0]      dataW_i,
    input  logic                 RegWEn_i,
    output logic [XLEN-1:0]      data1_o,
    output logic [XLEN-1:0]      data2_o
);

    // x1..x31 only; x0 has no storage and is produced by the read logic.
    word_t regs [1:NREG-1];

    // A write lands only when enabled, out of reset and not aimed at x0.
    logic write_hit;
    assign write_hit = RegWEn_i && !rst_ni && (rsW_i != '0);

    word_t stored1;
    word_t stored2;

    // Storage update: reset clears every register and wins over a write.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            for (int i = 1; i < NREG; i++) begin
                if (rsW_i == REG_IDX_W'(i)) begin
                    regs[i] <= dataW_i;
                end
            end
        end
    end

    // Stored-value read mux for both ports; index 0 falls through to zero.
    always_comb begin
        stored1 = '0;
        stored2 = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs1_i == REG_IDX_W'(i)) stored1 = regs[i];
            if (rs2_i == REG_IDX_W'(i)) stored2 = regs[i];
        end
    end

    // Output select: zero during reset, bypassed write data on an index
    // match, otherwise the stored value.
    always_comb begin
        data1_o = stored1;
        data2_o = stored2;
        if (rst_ni) begin
            data1_o = '0;
            data2_o = '0;
        end else begin
            if (write_hit && (rs1_i == rsW_i)) data1_o = dataW_i;
            if (write_hit && (rs2_i == rsW_i)) data2_o = dataW_i;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed plus randomized bench for the register file, using a reference
// model and an expected-value queue popped at each read check.
module tb_regfile;
    import regfile_pkg::*;

    logic                 clk;
    logic                 rst_ni;
    logic [REG_IDX_W-1:0] rs1_i;
    logic [REG_IDX_W-1:0] rs2_i;
    logic [REG_IDX_W-1:0] rsW_i;
    logic [XLEN-1:0]      dataW_i;
    logic                 RegWEn_i;
    logic [XLEN-1:0]      data1_o;
    logic [XLEN-1:0]      data2_o;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] exp_q[$];
    word_t           model [0:NREG-1];

    regfile dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rsW_i    (rsW_i),
        .dataW_i  (dataW_i),
        .RegWEn_i (RegWEn_i),
        .data1_o  (data1_o),
        .data2_o  (data2_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a full input vector just after the falling edge.
    task automatic drive(input logic rst, input logic we,
                         input logic [REG_IDX_W-1:0] rsw, input word_t dw,
                         input logic [REG_IDX_W-1:0] r1,
                         input logic [REG_IDX_W-1:0] r2);
        @(negedge clk);
        rst_ni   = rst;
        RegWEn_i = we;
        rsW_i    = rsw;
        dataW_i  = dw;
        rs1_i    = r1;
        rs2_i    = r2;
    endtask

    task automatic push_exp(input word_t e1, input word_t e2);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
    endtask

    // Pop two expectations and compare against both read ports.
    task automatic check(input string tag);
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        #1;
        if (exp_q.size() < 2) begin
            total++;
            bad++;
            $display("FAIL %s: expected queue empty", tag);
            return;
        end
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        total++;
        assert (data1_o === e1) else begin
            bad++;
            $error("FAIL %s data1 got %h expected %h", tag, data1_o, e1);
        end
        total++;
        assert (data2_o === e2) else begin
            bad++;
            $error("FAIL %s data2 got %h expected %h", tag, data2_o, e2);
        end
    endtask

    // Reference read with bypass, for the randomized phase.
    function automatic word_t model_read(input logic [REG_IDX_W-1:0] idx,
                                         input logic we,
                                         input logic [REG_IDX_W-1:0] rsw,
                                         input word_t dw);
        if (idx == '0) return '0;
        if (we && rsw != '0 && idx == rsw) return dw;
        return model[idx];
    endfunction

    initial begin
        logic                 r_we;
        logic [REG_IDX_W-1:0] r_w, r_1, r_2;
        word_t                r_d;

        rst_ni = 1'b1; RegWEn_i = 1'b0; rsW_i = '0; dataW_i = '0;
        rs1_i = '0; rs2_i = '0;
        for (int i = 0; i < NREG; i++) model[i] = '0;

        // Reset held for two edges; outputs read zero while asserted.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
        push_exp(32'h0, 32'h0);
        check("reset_active");
        drive(1'b1, 1'b1, 5'd2, 32'h1234, 5'd2, 5'd5);
        push_exp(32'h0, 32'h0);
        check("reset_no_bypass");

        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
        push_exp(32'h0, 32'h0);
        check("after_reset");

        // Write x5 = 0x214 (bypassed in the same cycle), then read back.
        drive(1'b0, 1'b1, 5'd5, 32'h214, 5'd0, 5'd5);
        push_exp(32'h0, 32'h214);
        check("write_x5_bypass");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        push_exp(32'h0, 32'h214);
        check("read_x5");

        // Write to x0 is discarded.
        drive(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
        push_exp(32'h0, 32'h0);
        check("x0_write_cycle");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        push_exp(32'h0, 32'h0);
        check("x0_after");

        // Bypass on x7, before and after the edge.
        drive(1'b0, 1'b1, 5'd7, 32'h55, 5'd7, 5'd5);
        push_exp(32'h55, 32'h214);
        check("bypass_x7_before");
        drive(1'b0, 1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
        push_exp(32'h55, 32'h55);
        check("bypass_x7_after");

        // Enable off: no write, no bypass.
        drive(1'b0, 1'b0, 5'd5, 32'h1, 5'd5, 5'd5);
        push_exp(32'h214, 32'h214);
        check("we_off_cycle");
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        push_exp(32'h214, 32'h0);
        check("we_off_after");

        model[5] = 32'h214;
        model[7] = 32'h55;

        // Randomized traffic checked against the reference model.
        for (int n = 0; n < 60; n++) begin
            r_we = ($urandom_range(0, 3) != 0);
            r_w  = REG_IDX_W'($urandom_range(0, NREG - 1));
            r_d  = $urandom();
            r_1  = REG_IDX_W'($urandom_range(0, NREG - 1));
            r_2  = (n % 4 == 0) ? r_1 : REG_IDX_W'($urandom_range(0, NREG - 1));
            if (n % 5 == 0) r_1 = r_w;
            drive(1'b0, r_we, r_w, r_d, r_1, r_2);
            push_exp(model_read(r_1, r_we, r_w, r_d),
                     model_read(r_2, r_we, r_w, r_d));
            check("random");
            if (r_we && r_w != '0) model[r_w] = r_d;
        end

        // Persistence sweep of every register.
        for (int i = 0; i < NREG; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, REG_IDX_W'(i), REG_IDX_W'(NREG - 1 - i));
            push_exp(model[i], model[NREG - 1 - i]);
            check("persist_sweep");
        end

        // Reset priority over a simultaneous write.
        drive(1'b1, 1'b1, 5'd3, 32'hFF, 5'd3, 5'd5);
        push_exp(32'h0, 32'h0);
        check("reset_prio_cycle");
        for (int i = 0; i < NREG; i++) model[i] = '0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
        push_exp(32'h0, 32'h0);
        check("reset_prio_after");
        for (int i = 0; i < NREG; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, REG_IDX_W'(i), REG_IDX_W'(NREG - 1 - i));
            push_exp(model[i], model[NREG - 1 - i]);
            check("cleared_sweep");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
